// File: rtl/arbitro_memoria_instrucao_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states and grant codes.
package arbitro_memoria_instrucao_pkg;

    typedef enum logic {
        StBoot = 1'b0,
        StRun  = 1'b1
    } estado_e;

    typedef enum logic [1:0] {
        GNone  = 2'd0,
        GFetch = 2'd1,
        GLoad  = 2'd2
    } grant_e;

    // Bit positions in the request/grant vectors handed to the round-robin picker
    localparam int unsigned IdxFetch = 0;
    localparam int unsigned IdxLoad  = 1;

endpackage

// File: rtl/arbitro_memoria_instrucao_rr2.sv
// Two-way round-robin picker. Purely combinational; the "last winner" register lives
// in the parent so it can be reset together with the rest of the arbiter state.
module arbitro_memoria_instrucao_rr2
    import arbitro_memoria_instrucao_pkg::*;
(
    input  logic [1:0] req,       // [IdxFetch]=fetch, [IdxLoad]=loader
    input  logic       last_load, // 1: loader won the most recent grant
    output logic [1:0] gnt
);

    // Lone requester wins; on contention the side that did not win last time goes
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_load ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/arbitro_memoria_instrucao.sv
// Arbiter sharing the single-port instruction memory between the fetch unit (reads) and
// the program loader (writes). Fetch is held off in BOOT until the loader reports done.
module arbitro_memoria_instrucao
    import arbitro_memoria_instrucao_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_data,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_data,
    output logic          l_ack,
    input  logic          l_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_q,
    output logic          boot,
    output logic [CW-1:0] stall_cnt
);

    estado_e       state_q, state_d;
    logic          last_load_q;
    logic          f_ack_q, l_ack_q;
    logic [DW-1:0] f_data_q;
    logic [CW-1:0] stall_q, stall_d;
    logic          f_elig, l_elig;
    logic [1:0]    gnt;
    grant_e        grant;

    // The ack mask stops a still-held request from being granted twice
    assign f_elig = f_req & ~f_ack_q & (state_q == StRun);
    assign l_elig = l_req & ~l_ack_q;

    arbitro_memoria_instrucao_rr2 u_rr2 (
        .req       ({l_elig, f_elig}),
        .last_load (last_load_q),
        .gnt       (gnt)
    );

    // Decode the one-hot picker output into a grant code
    always_comb begin
        grant = GNone;
        if (gnt[IdxFetch]) begin
            grant = GFetch;
        end else if (gnt[IdxLoad]) begin
            grant = GLoad;
        end
    end

    // BOOT -> RUN once the loader signals completion; only reset returns to BOOT
    always_comb begin
        state_d = state_q;
        if ((state_q == StBoot) && l_done) begin
            state_d = StRun;
        end
    end

    // Saturating count of RUN cycles where fetch was eligible but lost
    always_comb begin
        stall_d = stall_q;
        if ((state_q == StRun) && f_elig && (grant != GFetch) && !(&stall_q)) begin
            stall_d = stall_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Memory port mux; the write enable is gated by RST so a granted write dies at once
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = f_addr;
        mem_data = l_data;
        unique case (grant)
            GLoad: begin
                mem_we   = ~RST;
                mem_addr = l_addr;
            end
            GFetch:  mem_addr = f_addr;
            default: ;
        endcase
    end

    // State, ack pulses, read-data capture and round-robin history
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StBoot;
            last_load_q <= 1'b1;
            f_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
            f_data_q    <= '0;
            stall_q     <= '0;
        end else begin
            state_q <= state_d;
            f_ack_q <= (grant == GFetch);
            l_ack_q <= (grant == GLoad);
            stall_q <= stall_d;
            if (grant == GFetch) begin
                f_data_q <= mem_q;
            end
            if (grant != GNone) begin
                last_load_q <= (grant == GLoad);
            end
        end
    end

    assign f_ack     = f_ack_q;
    assign l_ack     = l_ack_q;
    assign f_data    = f_data_q;
    assign boot      = (state_q == StBoot);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_arbitro_memoria_instrucao.sv
// Bench for the instruction-memory arbiter: memory model, cycle-level reference model,
// read-data scoreboard and directed plus randomized stimulus.
module tb_arbitro_memoria_instrucao;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int StallMax = (1 << CW) - 1;
    localparam int WNone  = 0;
    localparam int WFetch = 1;
    localparam int WLoad  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_ack;
    logic [DW-1:0] f_data;
    logic          l_req = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_data = '0;
    logic          l_ack;
    logic          l_done = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic          boot;
    logic [CW-1:0] stall_cnt;

    always #5 CLK = ~CLK;

    arbitro_memoria_instrucao #(
        .AW (AW),
        .DW (DW),
        .CW (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .f_data    (f_data),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .l_ack     (l_ack),
        .l_done    (l_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_q     (mem_q),
        .boot      (boot),
        .stall_cnt (stall_cnt)
    );

    // Instruction memory: combinational read, write on posedge
    logic [DW-1:0] mem [0:1023];
    assign mem_q = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [0:1023];
    bit            m_boot = 1, m_f_ack = 0, m_l_ack = 0, m_last_load = 1;
    int            m_stall = 0;
    int            p_win = WNone;
    logic [AW-1:0] p_faddr, p_laddr;
    logic [DW-1:0] p_ldata;
    bit            p_ldone = 0, p_stall = 0;
    logic [DW-1:0] sb [$];

    // Mid-cycle: compare outputs to the model, then decide this cycle's winner
    always @(negedge CLK) begin : model_decide
        bit fe, le;
        int win;
        check("f_ack", 64'(f_ack), 64'(m_f_ack));
        check("l_ack", 64'(l_ack), 64'(m_l_ack));
        check("boot", 64'(boot), 64'(m_boot));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (RST) begin
            check("mem_we_in_reset", 64'(mem_we), 64'(0));
            p_win = WNone;
        end else begin
            fe = f_req && !m_f_ack && !m_boot;
            le = l_req && !m_l_ack;
            if (fe && le)  win = m_last_load ? WFetch : WLoad;
            else if (fe)   win = WFetch;
            else if (le)   win = WLoad;
            else           win = WNone;
            check("mem_we", 64'(mem_we), 64'(win == WLoad));
            if (win == WLoad) begin
                check("mem_addr_load", 64'(mem_addr), 64'(l_addr));
                check("mem_data_load", 64'(mem_data), 64'(l_data));
            end else begin
                check("mem_addr_fetch", 64'(mem_addr), 64'(f_addr));
            end
            p_win   = win;
            p_faddr = f_addr;
            p_laddr = l_addr;
            p_ldata = l_data;
            p_ldone = m_boot && l_done;
            p_stall = fe && (win != WFetch);
        end
    end

    // Clock edge: commit the decided action, or wipe everything on reset
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_boot = 1; m_f_ack = 0; m_l_ack = 0; m_last_load = 1; m_stall = 0;
            p_win = WNone; p_ldone = 0; p_stall = 0;
            sb.delete();
        end else begin
            m_f_ack = (p_win == WFetch);
            m_l_ack = (p_win == WLoad);
            if (p_win == WFetch) sb.push_back(ref_mem[p_faddr]);
            if (p_win == WLoad) ref_mem[p_laddr] = p_ldata;
            if (p_win != WNone) m_last_load = (p_win == WLoad);
            if (p_ldone) m_boot = 0;
            if (p_stall && m_stall < StallMax) m_stall++;
            p_win = WNone; p_ldone = 0; p_stall = 0;
        end
    end

    // Monitor: each fetch ack must deliver the data the scoreboard expects
    always @(negedge CLK) begin
        if (f_ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL f_data_sb: f_ack with data %0h, required no ack", f_data);
            end else begin
                check("f_data", 64'(f_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        bit got = 0;
        l_addr = a; l_data = d; l_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = l_ack;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL l_ack_timeout: got no l_ack in 40 cycles, required one");
        end
        @(posedge CLK); #1;
        if (gap > 0) begin
            l_req = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic fe_read(input logic [AW-1:0] a, input int gap);
        bit got = 0;
        f_addr = a; f_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = f_ack;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL f_ack_timeout: got no f_ack in 40 cycles, required one");
        end
        @(posedge CLK); #1;
        if (gap > 0) begin
            f_req = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] old;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Loader write in BOOT; fetch must be ignored
        ld_write(10'h005, 32'hDEADBEEF, 1);
        check("boot_after_write", 64'(boot), 64'(1));
        check("mem5_written", 64'(mem[5]), 64'h0DEADBEEF);
        f_addr = 10'h005; f_req = 1'b1;
        repeat (8) begin @(posedge CLK); #1; end
        f_req = 1'b0;
        check("stall_in_boot", 64'(stall_cnt), 64'(0));

        // Enter RUN, then read back
        l_done = 1'b1;
        @(posedge CLK); #1 l_done = 1'b0;
        check("boot_cleared", 64'(boot), 64'(0));
        fe_read(10'h005, 1);
        check("f_data_5", 64'(f_data), 64'h0DEADBEEF);

        // Sustained contention, back-to-back on both sides
        fork
            begin for (int i = 0; i < 20; i++) ld_write(AW'(10'h100 + i), $urandom, 0); l_req = 1'b0; end
            begin for (int i = 0; i < 20; i++) fe_read(AW'(10'h100 + i), 0); f_req = 1'b0; end
        join
        repeat (2) begin @(posedge CLK); #1; end

        // Randomized traffic over a small address window so reads hit written words
        fork
            begin
                repeat (40) ld_write(AW'($urandom_range(10'h100, 10'h10F)), $urandom,
                                     int'($urandom_range(0, 3)));
                l_req = 1'b0;
            end
            begin
                repeat (40) fe_read(AW'($urandom_range(10'h100, 10'h10F)),
                                    int'($urandom_range(0, 3)));
                f_req = 1'b0;
            end
        join
        repeat (2) begin @(posedge CLK); #1; end

        // Loader with one idle cycle between writes forces fetch to lose repeatedly
        fork
            begin for (int i = 0; i < 25; i++) ld_write(AW'(10'h200 + i), $urandom, 1); l_req = 1'b0; end
            begin repeat (40) fe_read(AW'($urandom_range(10'h100, 10'h10F)), 0); f_req = 1'b0; end
        join
        check("stall_saturated", 64'(stall_cnt), 64'hF);
        repeat (2) begin @(posedge CLK); #1; end
        check("stall_holds", 64'(stall_cnt), 64'hF);

        // Asynchronous reset while a write is granted
        old = mem[10'h123];
        l_addr = 10'h123; l_data = 32'hCAFEF00D; l_req = 1'b1;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("mem_we_async_drop", 64'(mem_we), 64'(0));
        check("l_ack_async", 64'(l_ack), 64'(0));
        l_req = 1'b0;
        @(posedge CLK); #1;
        check("boot_after_rst", 64'(boot), 64'(1));
        check("stall_after_rst", 64'(stall_cnt), 64'(0));
        @(posedge CLK); #1 RST = 1'b0;
        check("mem_no_write", 64'(mem[10'h123]), 64'(old));

        // Write and l_done in the same cycle: ack lands in the first RUN cycle
        l_addr = 10'h3FF; l_data = 32'h12345678; l_req = 1'b1; l_done = 1'b1;
        @(posedge CLK); #1 l_done = 1'b0;
        check("boot_run_again", 64'(boot), 64'(0));
        check("l_ack_first_run", 64'(l_ack), 64'(1));
        @(posedge CLK); #1 l_req = 1'b0;
        check("mem3ff_written", 64'(mem[10'h3FF]), 64'h012345678);
        fe_read(10'h3FF, 1);
        check("f_data_3ff", 64'(f_data), 64'h012345678);

        repeat (3) begin @(posedge CLK); #1; end
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
